// File: rtl/rr_cs_scheduler_if.sv
// Request/grant bundle between requesters and the round-robin chip-select scheduler.
interface rr_cs_scheduler_if;
  logic       en;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] cs_n;
  logic       busy;
  logic       timeout;

  modport master (output en, output req, input sel, input cs_n, input busy, input timeout);
  modport slave  (input en, input req, output sel, output cs_n, output busy, output timeout);
endinterface

// File: rtl/rr_cs_scheduler.sv
// Round-robin owner of one 8-way resource: registered sel/cs_n, bounded hold time,
// and a fixed all-deselected turnaround gap between consecutive grants.
module rr_cs_scheduler #(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_cs_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state, state_nxt;
  logic [2:0] last, last_nxt;
  logic [7:0] hold, hold_nxt;
  logic [3:0] gap, gap_nxt;
  logic [2:0] sel_q, sel_nxt;
  logic [7:0] cs_q, cs_nxt;
  logic       busy_q, busy_nxt;
  logic       tmo_q, tmo_nxt;

  logic       win_vld;
  logic [2:0] win;

  // Scan from last+8 down to last+1 so the nearest requester after last wins;
  // last itself (offset 8) is thereby the lowest priority.
  always_comb begin
    logic [2:0] idx;
    win_vld = 1'b0;
    win     = last;
    idx     = last;
    for (int k = 8; k >= 1; k--) begin
      idx = last + 3'(k);
      if (bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
    win_vld = win_vld & bus.en;
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    hold_nxt  = hold;
    gap_nxt   = gap;
    sel_nxt   = sel_q;
    cs_nxt    = cs_q;
    busy_nxt  = busy_q;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          sel_nxt   = win;
          cs_nxt    = ~(8'b1 << win);
          busy_nxt  = 1'b1;
          hold_nxt  = 8'd1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || hold == 8'(MAX_HOLD)) begin
          state_nxt = GAP;
          cs_nxt    = 8'hFF;
          busy_nxt  = 1'b0;
          last_nxt  = sel_q;
          gap_nxt   = 4'd1;
          tmo_nxt   = bus.req[sel_q];
        end else begin
          hold_nxt  = hold + 8'd1;
        end
      end
      GAP: begin
        if (gap == 4'(GAP_CYCLES)) begin
          if (win_vld) begin
            state_nxt = GRANT;
            sel_nxt   = win;
            cs_nxt    = ~(8'b1 << win);
            busy_nxt  = 1'b1;
            hold_nxt  = 8'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 3'd7;
      hold   <= 8'd0;
      gap    <= 4'd0;
      sel_q  <= 3'd0;
      cs_q   <= 8'hFF;
      busy_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      hold   <= hold_nxt;
      gap    <= gap_nxt;
      sel_q  <= sel_nxt;
      cs_q   <= cs_nxt;
      busy_q <= busy_nxt;
      tmo_q  <= tmo_nxt;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.cs_n    = cs_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = tmo_q;

endmodule

// File: tb/tb_rr_cs_scheduler.sv
// Random and directed stimulus on two scheduler configurations, each compared every
// cycle against a behavioural owner/gap model.
module tb_rr_cs_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] req = 8'h00;

  int total = 0;
  int bad   = 0;

  rr_cs_scheduler_if ifa();
  rr_cs_scheduler_if ifb();
  assign ifa.en = en;
  assign ifa.req = req;
  assign ifb.en = en;
  assign ifb.req = req;

  rr_cs_scheduler #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  rr_cs_scheduler #(.MAX_HOLD(1), .GAP_CYCLES(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  // model state per instance: owner=-1 means nobody holds the resource
  int mh[2] = '{4, 1};
  int gp[2] = '{1, 2};
  int owner[2], glen[2], gcnt[2], in_gap[2], last[2], msel[2], tmo[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1; glen[i] = 0; gcnt[i] = 0; in_gap[i] = 0;
      last[i] = 7; msel[i] = 0; tmo[i] = 0;
    end
  endtask

  task automatic pick(input int i);
    bit found = 0;
    if (en) begin
      for (int k = 1; k <= 8; k++) begin
        int idx = (last[i] + k) % 8;
        if (!found && req[idx]) begin
          found = 1; owner[i] = idx; msel[i] = idx; glen[i] = 1;
        end
      end
    end
  endtask

  task automatic model_step(input int i);
    tmo[i] = 0;
    if (owner[i] >= 0) begin
      if (!req[owner[i]]) begin
        last[i] = owner[i]; owner[i] = -1; in_gap[i] = 1; gcnt[i] = 1;
      end else if (glen[i] == mh[i]) begin
        tmo[i] = 1;
        last[i] = owner[i]; owner[i] = -1; in_gap[i] = 1; gcnt[i] = 1;
      end else begin
        glen[i]++;
      end
    end else if (in_gap[i] && gcnt[i] < gp[i]) begin
      gcnt[i]++;
    end else begin
      in_gap[i] = 0;
      pick(i);
    end
  endtask

  task automatic chk_inst(input int i, input logic [2:0] s, input logic [7:0] cs,
                          input logic b, input logic t);
    logic [7:0] want_cs;
    string p;
    p = (i == 0) ? "a" : "b";
    want_cs = (owner[i] >= 0) ? ~(8'b1 << owner[i]) : 8'hFF;
    chk({p, ".sel"}, 32'(s), 32'(msel[i]));
    chk({p, ".cs_n"}, 32'(cs), 32'(want_cs));
    chk({p, ".busy"}, 32'(b), 32'(owner[i] >= 0));
    chk({p, ".timeout"}, 32'(t), 32'(tmo[i]));
    chk({p, ".onehot"}, 32'($countones(~cs) <= 1), 32'd1);
  endtask

  task automatic check_all();
    chk_inst(0, ifa.sel, ifa.cs_n, ifa.busy, ifa.timeout);
    chk_inst(1, ifb.sel, ifb.cs_n, ifb.busy, ifb.timeout);
  endtask

  // called at a negedge; returns at the next negedge after checking
  task automatic cycle(input logic e, input logic [7:0] r);
    en = e; req = r;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] r;
    logic e;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int c = 0; c < 10; c++) cycle(1'b1, 8'h00);
    for (int c = 0; c < 3; c++) cycle(1'b1, 8'h08);
    for (int c = 0; c < 6; c++) cycle(1'b1, 8'h00);
    for (int c = 0; c < 20; c++) cycle(1'b1, 8'h08);
    for (int c = 0; c < 6; c++) cycle(1'b1, 8'h00);

    do_reset();
    for (int c = 0; c < 24; c++) cycle(1'b1, 8'h24);
    do_reset();
    for (int c = 0; c < 40; c++) cycle(1'b1, 8'hFF);

    // async reset during requester 6's second grant cycle on instance a
    do_reset();
    n = 0;
    while (!(owner[0] == 6 && glen[0] == 2) && n < 20) begin
      cycle(1'b1, 8'h40);
      n++;
    end
    chk("wait_grant6", 32'(owner[0] == 6 && glen[0] == 2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cs_n", 32'(ifa.cs_n), 32'hFF);
    chk("async_busy", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) cycle(1'b1, 8'h40);

    do_reset();
    for (int c = 0; c < 10; c++) cycle(1'b0, 8'hFF);

    for (int c = 0; c < 500; ) begin
      n = $urandom_range(1, 6);
      r = 8'($urandom) & 8'($urandom);
      e = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < n; k++) begin
        cycle(e, r);
        c++;
      end
      if ($urandom_range(0, 60) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_cs_scheduler.md
Name: rr_cs_scheduler

Overview:
- Round-robin scheduler that shares one 8-way resource between 8 requesters.
- Drives the 3-bit select index plus the matching active-low one-hot chip-select vector: the selected line is 0, all others 1.
- Sits in front of the 3-to-8 select decode path and sequences grants.
- Grants are held while the requester keeps asserting, bounded by a maximum hold time, and are separated by a turnaround gap.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may last; legal range 1..255.
- GAP_CYCLES, 1, dead cycles with all chip-selects high between grants; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = new grants allowed; 0 = no new grant is issued (a grant in progress still completes normally).
- req  input  8  request vector; req[i]=1 means requester i wants the resource.
- sel  output  3  index of the current or most recent grantee.
- cs_n  output  8  active-low one-hot select; cs_n[sel]=0 only while granted, otherwise 8'hFF.
- busy  output  1  1 while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- All outputs are registered. States: IDLE, GRANT, GAP.
- Internal registers: last pointer (3b), hold counter (8b), gap counter (4b).
- rst_n low, at any time and asynchronously:
  - State IDLE, cs_n=8'hFF, sel=0, busy=0, timeout=0.
  - Last pointer=7, hold and gap counters=0.
  - A grant in progress is dropped immediately.
- Arbitration (combinational):
  - Winner = first i with req[i]=1, searching last+1, last+2, ... wrapping modulo 8.
  - Valid only if en=1 and req is nonzero.
- IDLE:
  - On an edge with a valid winner W: go to GRANT; sel=W, cs_n=~(8'b1<<W), busy=1, hold counter=1.
  - Latency: req sampled at edge k, so cs_n is low from edge k. No combinational path from req to cs_n.
- GRANT, evaluated at each edge in this priority order:
  - (a) req[sel]=0: release; timeout stays 0.
  - (b) else if hold counter == MAX_HOLD: release and pulse timeout=1 for exactly one cycle.
  - (c) else: hold counter increments and the grant continues.
  - A continuously requesting grantee therefore sees cs_n low for exactly MAX_HOLD cycles.
  - A grantee dropping req is released at the first edge that samples req[sel]=0.
- Release actions:
  - State GAP, cs_n=8'hFF, busy=0, last=sel.
  - sel keeps its value; gap counter=1.
- GAP:
  - cs_n stays 8'hFF for exactly GAP_CYCLES cycles.
  - At the edge where gap counter == GAP_CYCLES, arbitrate using the updated last pointer:
    - valid winner: enter GRANT directly with the same actions as from IDLE;
    - otherwise: enter IDLE.
  - Any other GAP edge increments the gap counter.
- Fairness:
  - The previous grantee has lowest priority at the next arbitration.
  - A lone requester is re-granted after the gap.
- en:
  - en=0 only suppresses new grants.
  - en=0 in GAP at the final gap edge sends the block to IDLE.
- Requests for indices other than sel, changing during GRANT, have no effect until the next arbitration.
- Invariant: at most one cs_n bit is 0 at any time. cs_n is never low in IDLE or GAP.
- Back-to-back grants can never overlap; there are at least GAP_CYCLES all-high cycles between them.

Test Plan:
1. Reset then idle: rst_n=0, req=8'h00, then rst_n=1 for 10 cycles → cs_n=8'hFF, sel=0, busy=0, timeout=0 throughout.
2. Single short burst: req=8'h08 for 3 cycles, then 0 → cs_n=8'hF7 and sel=3 for 3 cycles, then 8'hFF; busy tracks the grant; timeout never pulses.
3. Timeout: MAX_HOLD=4, GAP_CYCLES=1, req=8'h08 held high →
   - repeating pattern 4 cycles 8'hF7, 1 cycle 8'hFF;
   - timeout=1 in each gap cycle.
4. Round-robin order: req=8'h24 held high from reset, MAX_HOLD=2 → grant sequence 2,5,2,5 (cs_n 8'hFB, 8'hDF alternating), each grant lasting 2 cycles.
5. Full contention rotation: req=8'hFF, MAX_HOLD=1, GAP_CYCLES=2 →
   - sel sequence 0..7 then 0;
   - each grant is 1 cycle followed by 2 all-high cycles;
   - one-hot invariant is checked every cycle.
6. Reset mid-grant and en:
   - rst_n pulsed low during the 2nd grant cycle of requester 6 → cs_n=8'hFF asynchronously; after release, req=8'h40 regranted with sel=6.
   - With en=0 and req=8'hFF → no grant is issued.
